wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 108 ++++++++++
 tb/tb_wb_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: three-way round-robin write-back arbiter in front of the register-file write port.
// Latency: a transfer accepted in cycle N appears on RegWrite_o/RDaddr_o/RDdata_o/grant_o in cycle N+1.
// Backpressure: req_ready_o is one-hot or zero; stall_i or rst_i holds every requester off that cycle.
//
// Parameters: DATA_W write-data width, ADDR_W register address width.
// Ports:
//   clk_i, rst_i (async, active-high)
//   req_valid_i[3], req_addr_i[3*ADDR_W], req_data_i[3*DATA_W], req_ready_o[3]  (0=ALU, 1=load, 2=mul/div)
//   stall_i                                       blocks all acceptance
//   RegWrite_o, RDaddr_o, RDdata_o, grant_o       registered register-file write port
// Optional build macro WB_ARB_R0_DROP_EN: writes to address 0 are handshaken but never issued.
module wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [2:0]          req_valid_i,
  input  logic [3*ADDR_W-1:0] req_addr_i,
  input  logic [3*DATA_W-1:0] req_data_i,
  output logic [2:0]          req_ready_o,
  input  logic                stall_i,
  output logic                RegWrite_o,
  output logic [ADDR_W-1:0]   RDaddr_o,
  output logic [DATA_W-1:0]   RDdata_o,
  output logic [2:0]          grant_o
);

  // Requester index that follows x in the 0 -> 1 -> 2 -> 0 ring.
  function automatic logic [1:0] ring_next(input logic [1:0] x);
    return (x >= 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  logic [1:0]        last_grant;
  logic [1:0]        cand0, cand1, cand2;
  logic [1:0]        sel;
  logic              sel_vld;
  logic              issue;
  logic [ADDR_W-1:0] addr_arr [3];
  logic [DATA_W-1:0] data_arr [3];
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      addr_arr[k] = req_addr_i[k*ADDR_W +: ADDR_W];
      data_arr[k] = req_data_i[k*DATA_W +: DATA_W];
    end
  end

  // Search order starts just after the last winner, so the last winner
  // is always considered last.
  always_comb begin
    cand0   = ring_next(last_grant);
    cand1   = ring_next(cand0);
    cand2   = ring_next(cand1);
    sel     = cand0;
    sel_vld = 1'b0;
    if (!rst_i && !stall_i) begin
      if (req_valid_i[cand0]) begin
        sel     = cand0;
        sel_vld = 1'b1;
      end else if (req_valid_i[cand1]) begin
        sel     = cand1;
        sel_vld = 1'b1;
      end else if (req_valid_i[cand2]) begin
        sel     = cand2;
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready_o = sel_vld ? (3'b001 << sel) : 3'b000;
    sel_addr    = addr_arr[sel];
    sel_data    = data_arr[sel];
  end

  // A transfer always advances the pointer; only the issued write is gated
  // when address 0 is configured as a discard target.
`ifdef WB_ARB_R0_DROP_EN
  assign issue = sel_vld && (sel_addr != '0);
`else
  assign issue = sel_vld;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant <= 2'd2;
      RegWrite_o <= 1'b0;
      grant_o    <= 3'b000;
      RDaddr_o   <= '0;
      RDdata_o   <= '0;
    end else begin
      if (sel_vld) begin
        last_grant <= sel;
      end
      RegWrite_o <= issue;
      grant_o    <= issue ? req_ready_o : 3'b000;
      // Address/data hold their last issued values on idle cycles.
      if (issue) begin
        RDaddr_o <= sel_addr;
        RDdata_o <= sel_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed stimulus for wb_arbiter with a cycle-level reference model
// and a per-cycle compare process, plus literal expectations at key points.
module tb_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic                clk;
  logic                rst;
  logic [2:0]          valid;
  logic [3*ADDR_W-1:0] addr_bus;
  logic [3*DATA_W-1:0] data_bus;
  logic [2:0]          ready;
  logic                stall;
  logic                reg_write;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   rd_data;
  logic [2:0]          grant;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(valid),
    .req_addr_i (addr_bus),
    .req_data_i (data_bus),
    .req_ready_o(ready),
    .stall_i    (stall),
    .RegWrite_o (reg_write),
    .RDaddr_o   (rd_addr),
    .RDdata_o   (rd_data),
    .grant_o    (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int k, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    addr_bus[k*ADDR_W +: ADDR_W] = a;
    data_bus[k*DATA_W +: DATA_W] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: who wins is the first valid requester walking the ring
  // from the one after the previous winner; what the write port shows is
  // simply whatever was won at the previous edge.
  int                m_last = 2;
  logic              m_we = 1'b0;
  logic [2:0]        m_grant = 3'b000;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_data = '0;

  always @(negedge clk) begin
    int   win;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    if (rst) begin
      m_last  = 2;
      m_we    = 1'b0;
      m_grant = 3'b000;
      m_addr  = '0;
      m_data  = '0;
    end
    chk("cyc_regwrite", {31'd0, reg_write}, {31'd0, m_we});
    chk("cyc_grant", {29'd0, grant}, {29'd0, m_grant});
    chk("cyc_addr", {27'd0, rd_addr}, {27'd0, m_addr});
    chk("cyc_data", rd_data, m_data);
    win = -1;
    if (!rst && !stall) begin
      for (int i = 1; i <= 3; i++) begin
        if (win < 0 && valid[(m_last + i) % 3]) win = (m_last + i) % 3;
      end
    end
    chk("cyc_ready", {29'd0, ready}, (win < 0) ? 32'd0 : (32'd1 << win));
    if (win >= 0) begin
      wa = addr_bus[win*ADDR_W +: ADDR_W];
      wd = data_bus[win*DATA_W +: DATA_W];
      m_last = win;
`ifdef WB_ARB_R0_DROP_EN
      if (wa == '0) begin
        m_we    = 1'b0;
        m_grant = 3'b000;
      end else begin
        m_we    = 1'b1;
        m_grant = 3'(1 << win);
        m_addr  = wa;
        m_data  = wd;
      end
`else
      m_we    = 1'b1;
      m_grant = 3'(1 << win);
      m_addr  = wa;
      m_data  = wd;
`endif
    end else begin
      m_we    = 1'b0;
      m_grant = 3'b000;
    end
  end

  initial begin
    rst      = 1'b1;
    stall    = 1'b0;
    valid    = 3'b111;
    addr_bus = '0;
    data_bus = '0;
    set_req(0, 5'd1, 32'hDEAD_0001);
    set_req(1, 5'd2, 32'hDEAD_0002);
    set_req(2, 5'd4, 32'hDEAD_0004);
    #2;
    chk("reset_ready", {29'd0, ready}, 32'd0);
    chk("reset_regwrite", {31'd0, reg_write}, 32'd0);
    tick();
    tick();
    rst   = 1'b0;
    valid = 3'b000;
    tick();

    // Single write from requester 0.
    set_req(0, 5'd3, 32'h11);
    valid = 3'b001;
    #1;
    chk("single_ready", {29'd0, ready}, 32'b001);
    tick();
    valid = 3'b000;
    chk("single_we", {31'd0, reg_write}, 32'd1);
    chk("single_addr", {27'd0, rd_addr}, 32'd3);
    chk("single_data", rd_data, 32'h11);
    chk("single_grant", {29'd0, grant}, 32'b001);
    tick();
    chk("idle_we", {31'd0, reg_write}, 32'd0);
    chk("idle_addr_hold", {27'd0, rd_addr}, 32'd3);

    // Same address from requesters 1 then 2; 0xBB must land last.
    set_req(1, 5'd7, 32'hAA);
    set_req(2, 5'd7, 32'hBB);
    valid = 3'b110;
    #1;
    chk("same_ready1", {29'd0, ready}, 32'b010);
    tick();
    valid = 3'b100;
    #1;
    chk("same_ready2", {29'd0, ready}, 32'b100);
    chk("same_first", rd_data, 32'hAA);
    tick();
    valid = 3'b000;
    chk("same_second", rd_data, 32'hBB);
    chk("same_second_addr", {27'd0, rd_addr}, 32'd7);
    tick();

    // All three continuously valid: strict rotation.
    for (int k = 0; k < 3; k++) set_req(k, 5'(10 + k), 32'h100 + k);
    valid = 3'b111;
    #1;
    chk("rr_first_ready", {29'd0, ready}, 32'b001);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("rr_grant", {29'd0, grant}, 32'd1 << (c % 3));
      if (c == 5) valid = 3'b000;
      else set_req(c % 3, 5'(10 + (c % 3)), 32'h200 + c);
    end
    tick();

    // Stall holds everyone off, then rotation resumes from requester 0.
    valid = 3'b011;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_ready", {29'd0, ready}, 32'd0);
      tick();
      chk("stall_we", {31'd0, reg_write}, 32'd0);
    end
    stall = 1'b0;
    #1;
    chk("post_stall_ready0", {29'd0, ready}, 32'b001);
    tick();
    valid = 3'b010;
    #1;
    chk("post_stall_ready1", {29'd0, ready}, 32'b010);
    chk("post_stall_grant0", {29'd0, grant}, 32'b001);
    tick();
    valid = 3'b000;
    chk("post_stall_grant1", {29'd0, grant}, 32'b010);
    tick();

    // Stall rising right after a transfer does not cancel its write.
    valid = 3'b001;
    #1;
    chk("late_stall_ready", {29'd0, ready}, 32'b001);
    tick();
    valid = 3'b000;
    stall = 1'b1;
    #1;
    chk("late_stall_we", {31'd0, reg_write}, 32'd1);
    tick();
    stall = 1'b0;

    // Lone requester accepted every cycle.
    set_req(2, 5'd20, 32'h2020);
    valid = 3'b100;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stream_ready", {29'd0, ready}, 32'b100);
      tick();
      chk("stream_grant", {29'd0, grant}, 32'b100);
    end
    valid = 3'b000;
    tick();

    // Address 0 write.
    set_req(1, 5'd0, 32'h55);
    valid = 3'b010;
    #1;
    chk("r0_ready", {29'd0, ready}, 32'b010);
    tick();
    valid = 3'b000;
`ifdef WB_ARB_R0_DROP_EN
    chk("r0_dropped_we", {31'd0, reg_write}, 32'd0);
    chk("r0_dropped_grant", {29'd0, grant}, 32'd0);
`else
    chk("r0_we", {31'd0, reg_write}, 32'd1);
    chk("r0_addr", {27'd0, rd_addr}, 32'd0);
    chk("r0_data", rd_data, 32'h55);
`endif
    tick();

    // Accepted transfer followed by reset before the capturing edge.
    set_req(2, 5'd9, 32'h99);
    valid = 3'b100;
    #1;
    chk("rst_xfer_ready", {29'd0, ready}, 32'b100);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_ready_zero", {29'd0, ready}, 32'd0);
    tick();
    chk("rst_no_write", {31'd0, reg_write}, 32'd0);
    chk("rst_addr_zero", {27'd0, rd_addr}, 32'd0);
    rst   = 1'b0;
    valid = 3'b111;
    #1;
    chk("after_rst_ready", {29'd0, ready}, 32'b001);
    tick();
    valid = 3'b000;
    chk("after_rst_grant", {29'd0, grant}, 32'b001);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
